lfsr_index_decoder: RTL and testbench

//  Inverse of the key-search LFSR counter: takes an LFSR state and returns its

---
 rtl/lfsr_index_decoder.sv | 129 ++++++++++++
 tb/tb_lfsr_index_decoder.sv | 255 +++++++++++++++++++++++++
 2 files changed

// File: rtl/lfsr_index_decoder.sv
// rtl/lfsr_index_decoder.sv - maps a key-search LFSR state back to its step index

module lfsr_index_decoder #(
  parameter int OP_MODE = 0,
  localparam int W = (OP_MODE == 0) ? 22 :
                     (OP_MODE == 1) ? 24 :
                     (OP_MODE == 2) ? 8  : 6
) (
  input  logic         clk_i,
  input  logic         reset_i,
  input  logic         start_i,
  input  logic [W-1:0] lfsr_state_i,
  output logic         busy_o,
  output logic         done_o,
  output logic         valid_o,
  output logic         error_o,
  output logic [W-1:0] index_o
);

  // Feedback taps must stay identical to the key counter this block inverts.
  localparam logic [23:0] TAPS_FULL = (W == 22) ? 24'h200001 :
                                      (W == 24) ? 24'h80000D :
                                      (W == 8)  ? 24'h00008E : 24'h000021;
  localparam logic [W-1:0] TAPS      = TAPS_FULL[W-1:0];
  localparam logic [W-1:0] SEED      = '1;
  // Last reachable index of a maximal-length sequence (2^W - 2).
  localparam logic [W-1:0] MAX_COUNT = {{(W-1){1'b1}}, 1'b0};

  typedef enum logic [1:0] {
    S_IDLE   = 2'd0,
    S_SEARCH = 2'd1,
    S_DONE   = 2'd2
  } state_t;

  state_t       state_q;
  logic [W-1:0] target_q;
  logic [W-1:0] cand_q;
  logic [W-1:0] count_q;
  logic [W-1:0] index_q;
  logic         busy_q;
  logic         done_q;
  logic         valid_q;
  logic         error_q;

  logic [W-1:0] cand_d;
  logic [W-1:0] count_d;

  // Next candidate and step count while walking the sequence from the seed.
  always_comb begin
    cand_d  = {cand_q[W-2:0], ^(cand_q & TAPS)};
    count_d = count_q + W'(1);
  end

  // Decode FSM; all outputs are registered. A zero target spends one silent
  // cycle in DONE before the done pulse so its latency matches a seed match.
  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      state_q  <= S_IDLE;
      target_q <= '0;
      cand_q   <= '0;
      count_q  <= '0;
      index_q  <= '0;
      busy_q   <= 1'b0;
      done_q   <= 1'b0;
      valid_q  <= 1'b0;
      error_q  <= 1'b0;
    end else begin
      case (state_q)
        S_IDLE: begin
          done_q <= 1'b0;
          if (start_i) begin
            target_q <= lfsr_state_i;
            valid_q  <= 1'b0;
            error_q  <= 1'b0;
            if (lfsr_state_i == '0) begin
              index_q <= '0;
              state_q <= S_DONE;
            end else begin
              cand_q  <= SEED;
              count_q <= '0;
              busy_q  <= 1'b1;
              state_q <= S_SEARCH;
            end
          end
        end
        S_SEARCH: begin
          if (cand_q == target_q) begin
            index_q <= count_q;
            valid_q <= 1'b1;
            busy_q  <= 1'b0;
            done_q  <= 1'b1;
            state_q <= S_DONE;
          end else if (count_q == MAX_COUNT) begin
            index_q <= '0;
            error_q <= 1'b1;
            busy_q  <= 1'b0;
            done_q  <= 1'b1;
            state_q <= S_DONE;
          end else begin
            cand_q  <= cand_d;
            count_q <= count_d;
          end
        end
        S_DONE: begin
          if (done_q) begin
            done_q  <= 1'b0;
            state_q <= S_IDLE;
          end else begin
            // Only the zero-target path arrives here without done set.
            done_q  <= 1'b1;
            error_q <= 1'b1;
          end
        end
        default: begin
          state_q <= S_IDLE;
          busy_q  <= 1'b0;
          done_q  <= 1'b0;
        end
      endcase
    end
  end

  assign busy_o  = busy_q;
  assign done_o  = done_q;
  assign valid_o = valid_q;
  assign error_o = error_q;
  assign index_o = index_q;

endmodule

// File: tb/tb_lfsr_index_decoder.sv
// tb/tb_lfsr_index_decoder.sv - self-checking bench for lfsr_index_decoder

module tb_lfsr_index_decoder;

  logic       clk = 1'b0;
  logic       reset_i = 1'b1;

  logic       start6 = 1'b0;
  logic [5:0] state6 = '0;
  logic       busy6, done6, valid6, error6;
  logic [5:0] index6;

  logic       start8 = 1'b0;
  logic [7:0] state8 = '0;
  logic       busy8, done8, valid8, error8;
  logic [7:0] index8;

  int cyc = 0;
  int checks = 0;
  int failures = 0;

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  lfsr_index_decoder #(.OP_MODE(3)) dut6 (
    .clk_i(clk), .reset_i(reset_i), .start_i(start6), .lfsr_state_i(state6),
    .busy_o(busy6), .done_o(done6), .valid_o(valid6), .error_o(error6), .index_o(index6)
  );

  lfsr_index_decoder #(.OP_MODE(2)) dut8 (
    .clk_i(clk), .reset_i(reset_i), .start_i(start8), .lfsr_state_i(state8),
    .busy_o(busy8), .done_o(done8), .valid_o(valid8), .error_o(error8), .index_o(index8)
  );

  typedef struct {
    logic [7:0] idx;
    logic       valid;
    logic       err;
    int         lat;
    int         busy;
  } exp_t;

  exp_t sb[$];

  typedef struct {
    logic [7:0] st;
    logic [7:0] idx;
    logic       valid;
    logic       err;
  } vec_t;

  vec_t vecs[5];

  task automatic check(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      failures++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  function automatic logic [7:0] ref_step(input logic [7:0] c, input int w, input logic [7:0] taps);
    logic [7:0] mask;
    logic       fb;
    mask = 8'((1 << w) - 1);
    fb   = ^(c & taps & mask);
    return ((c << 1) | {7'd0, fb}) & mask;
  endfunction

  function automatic logic [7:0] ref_state(input int steps, input int w, input logic [7:0] taps);
    logic [7:0] s;
    s = 8'((1 << w) - 1);
    for (int i = 0; i < steps; i++) s = ref_step(s, w, taps);
    return s;
  endfunction

  function automatic logic get_done(input int d);
    return (d == 0) ? done6 : done8;
  endfunction

  function automatic logic get_busy(input int d);
    return (d == 0) ? busy6 : busy8;
  endfunction

  function automatic logic get_valid(input int d);
    return (d == 0) ? valid6 : valid8;
  endfunction

  function automatic logic get_error(input int d);
    return (d == 0) ? error6 : error8;
  endfunction

  function automatic logic [7:0] get_index(input int d);
    return (d == 0) ? {2'b00, index6} : index8;
  endfunction

  // Push the expectation when stimulus goes in.
  task automatic expect_result(input logic [7:0] idx, input logic v, input logic e);
    exp_t x;
    x.idx   = idx;
    x.valid = v;
    x.err   = e;
    x.lat   = e ? 2 : int'(idx) + 2;
    x.busy  = e ? 0 : int'(idx) + 1;
    sb.push_back(x);
  endtask

  // Wait (bounded) for done, then pop and compare; called after start is deasserted.
  task automatic collect(input int d, input int t0, input int busy_seen_in, input int bound,
                         input string tag);
    int   busy_seen;
    exp_t x;
    busy_seen = busy_seen_in;
    for (int k = 0; k < bound; k++) begin
      if (get_done(d)) break;
      if (get_busy(d)) busy_seen++;
      @(negedge clk);
    end
    if (!get_done(d)) begin
      checks++;
      failures++;
      $display("FAIL %s_timeout: no done within %0d cycles", tag, bound);
      if (sb.size() > 0) void'(sb.pop_front());
      return;
    end
    x = sb.pop_front();
    check({tag, "_index"}, int'(get_index(d)), int'(x.idx));
    check({tag, "_valid"}, int'(get_valid(d)), int'(x.valid));
    check({tag, "_error"}, int'(get_error(d)), int'(x.err));
    check({tag, "_latency"}, cyc - t0, x.lat);
    check({tag, "_busy_cycles"}, busy_seen, x.busy);
    @(negedge clk);
    check({tag, "_done_one_cycle"}, int'(get_done(d)), 0);
    check({tag, "_valid_held"}, int'(get_valid(d)), int'(x.valid));
  endtask

  task automatic decode(input int d, input logic [7:0] st, input int bound, input string tag);
    int t0;
    @(negedge clk);
    if (d == 0) begin start6 = 1'b1; state6 = st[5:0]; end
    else        begin start8 = 1'b1; state8 = st;      end
    t0 = cyc;
    @(negedge clk);
    start6 = 1'b0;
    start8 = 1'b0;
    collect(d, t0, 0, bound, tag);
  endtask

  initial begin
    logic [7:0] s;
    int         t0;
    int         bad;
    logic [62:0] seen;

    vecs[0] = '{st: 8'h3F, idx: 8'd0, valid: 1'b1, err: 1'b0};
    vecs[1] = '{st: 8'h3E, idx: 8'd1, valid: 1'b1, err: 1'b0};
    vecs[2] = '{st: 8'h3D, idx: 8'd2, valid: 1'b1, err: 1'b0};
    vecs[3] = '{st: 8'h3A, idx: 8'd3, valid: 1'b1, err: 1'b0};
    vecs[4] = '{st: 8'h00, idx: 8'd0, valid: 1'b0, err: 1'b1};

    repeat (3) @(negedge clk);
    reset_i = 1'b0;
    @(negedge clk);
    check("reset_busy",  int'(busy6),  0);
    check("reset_done",  int'(done6),  0);
    check("reset_valid", int'(valid6), 0);
    check("reset_error", int'(error6), 0);
    check("reset_index", int'(index6), 0);

    // Table-driven single decodes, including the zero-state error case.
    for (int i = 0; i < 5; i++) begin
      expect_result(vecs[i].idx, vecs[i].valid, vecs[i].err);
      decode(0, vecs[i].st, 100, $sformatf("vec%0d", i));
    end

    // Full sweep of the 6-bit sequence against a reference LFSR.
    s = 8'h3F;
    seen = '0;
    bad = 0;
    for (int i = 0; i < 63; i++) begin
      if (s == 8'h00 || seen[s[5:0] - 6'd1]) bad++;
      seen[s[5:0] - 6'd1] = 1'b1;
      expect_result(8'(i), 1'b1, 1'b0);
      decode(0, s, 100, $sformatf("sweep%0d", i));
      s = ref_step(s, 6, 8'h21);
    end
    check("sweep_states_distinct", bad, 0);
    check("sweep_period", int'(s), 8'h3F);

    // Restart and new state mid-search are ignored; start during DONE too.
    expect_result(8'd3, 1'b1, 1'b0);
    @(negedge clk);
    start6 = 1'b1; state6 = 6'h3A; t0 = cyc;
    @(negedge clk);
    start6 = 1'b0;
    check("restart_busy", int'(busy6), 1);
    @(negedge clk);
    start6 = 1'b1; state6 = 6'h3E;
    @(negedge clk);
    start6 = 1'b0; state6 = 6'h00;
    collect(0, t0, 2, 100, "restart");
    // collect ended one cycle after done; now pulse start while in DONE via a fresh decode
    expect_result(8'd2, 1'b1, 1'b0);
    @(negedge clk);
    start6 = 1'b1; state6 = 6'h3D; t0 = cyc;
    @(negedge clk);
    start6 = 1'b0;
    for (int k = 0; k < 100 && !done6; k++) @(negedge clk);
    start6 = 1'b1; state6 = 6'h3F;
    collect(0, t0, 3, 1, "done_start");
    start6 = 1'b0;
    bad = 0;
    for (int k = 0; k < 10; k++) begin
      if (done6 || busy6) bad++;
      @(negedge clk);
    end
    check("start_in_done_ignored", bad, 0);

    // Reset in the middle of a search aborts with no done pulse.
    @(negedge clk);
    start6 = 1'b1; state6 = ref_state(40, 6, 8'h21);
    @(negedge clk);
    start6 = 1'b0;
    repeat (5) @(negedge clk);
    check("pre_reset_busy", int'(busy6), 1);
    reset_i = 1'b1;
    @(negedge clk);
    reset_i = 1'b0;
    check("midreset_busy",  int'(busy6),  0);
    check("midreset_done",  int'(done6),  0);
    check("midreset_valid", int'(valid6), 0);
    check("midreset_error", int'(error6), 0);
    check("midreset_index", int'(index6), 0);
    bad = 0;
    for (int k = 0; k < 60; k++) begin
      if (done6 || busy6) bad++;
      @(negedge clk);
    end
    check("midreset_no_done", bad, 0);

    // 8-bit variant.
    expect_result(8'd200, 1'b1, 1'b0);
    decode(1, ref_state(200, 8, 8'h8E), 300, "w8_200");

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #2_000_000;
    $display("FAIL global_timeout: simulation did not finish");
    $fatal(1, "timeout");
  end

endmodule
